// File: rtl/axi_reorder_cmp_pkg.sv
// Shared types for the AXI reorder/ordering monitor: default channel structs,
// the address-region rule type and the error classification.
package axi_reorder_cmp_pkg;

  localparam int unsigned DefIdWidth = 3;

  typedef logic [31:0]           axi_addr_t;
  typedef logic [DefIdWidth-1:0] axi_id_t;

  typedef enum logic [1:0] {
    UNMAPPED,
    OVERFLOW,
    NO_OUTSTANDING,
    NO_SLAVE_RSP
  } err_kind_e;

  typedef struct packed {
    logic [31:0] idx;
    axi_addr_t   start_addr;
    axi_addr_t   end_addr;
  } axi_rule_t;

  localparam axi_rule_t DefaultRule = '0;

  typedef struct packed { axi_id_t id; axi_addr_t addr; } axi_aw_chan_t;
  typedef struct packed { logic [31:0] data; logic last; } axi_w_chan_t;
  typedef struct packed { axi_id_t id; logic [1:0] resp; } axi_b_chan_t;
  typedef struct packed { axi_id_t id; axi_addr_t addr; } axi_ar_chan_t;
  typedef struct packed { axi_id_t id; logic [31:0] data; logic [1:0] resp; logic last; } axi_r_chan_t;

  typedef struct packed {
    axi_aw_chan_t aw; logic aw_valid;
    axi_w_chan_t  w;  logic w_valid;
    logic         b_ready;
    axi_ar_chan_t ar; logic ar_valid;
    logic         r_ready;
  } axi_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        ar_ready;
    logic        w_ready;
    logic        b_valid; axi_b_chan_t b;
    logic        r_valid; axi_r_chan_t r;
  } axi_rsp_t;

endpackage

// File: rtl/axi_reorder_cmp_idq.sv
// Circular FIFO of slave indices; one instance tracks the issue order of one
// ID in one direction. A push while full is dropped unless a pop frees a slot.
module axi_reorder_cmp_idq
  import axi_reorder_cmp_pkg::*;
#(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] data,
  output logic [Width-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wptr, rptr;
  logic [CntW-1:0]  count;
  logic             push_ok, pop_ok;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full    = (count == CntW'(Depth));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head    = mem[rptr];

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_ni) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= next_ptr(wptr);
      if (pop_ok)  rptr <= next_ptr(rptr);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: ;
      endcase
    end
  end

  // NOTE: storage is not reset; the pointers and count alone define which
  // entries are valid, so the array can map onto plain flops or RAM.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wptr] <= data;
  end

endmodule

// File: rtl/axi_reorder_cmp.sv
// AXI ordering monitor: matches master B/R responses against per-ID issue order
// and slave-side responses. Define AXI_REORDER_CMP_ASSERT_EN for $error reporting.
module axi_reorder_cmp
  import axi_reorder_cmp_pkg::*;
#(
  parameter int unsigned NumSlaves      = 4,
  parameter int unsigned AxiIdWidth     = 3,
  parameter int unsigned NumAddrRegions = 4,
  parameter type addr_t    = axi_addr_t,
  parameter type rule_t    = axi_rule_t,
  parameter rule_t [NumAddrRegions-1:0] AddrRegions = '0,
  parameter type aw_chan_t = axi_aw_chan_t,
  parameter type w_chan_t  = axi_w_chan_t,
  parameter type b_chan_t  = axi_b_chan_t,
  parameter type ar_chan_t = axi_ar_chan_t,
  parameter type r_chan_t  = axi_r_chan_t,
  parameter type req_t     = axi_req_t,
  parameter type rsp_t     = axi_rsp_t,
  parameter int unsigned MaxTxnsPerId   = 8,
  parameter int unsigned NumWrites      = 1000,
  parameter int unsigned NumReads       = 1000,
  parameter bit          Verbose        = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  req_t                 mon_mst_req_i,
  input  rsp_t                 mon_mst_rsp_i,
  input  req_t [NumSlaves-1:0] mon_slv_req_i,
  input  rsp_t [NumSlaves-1:0] mon_slv_rsp_i,
  output logic                 end_of_sim_o,
  output logic                 error_o,
  output logic [31:0]          err_cnt_o
);

  localparam int unsigned NumIds = 2 ** AxiIdWidth;
  localparam int unsigned SlvW   = (NumSlaves > 1) ? $clog2(NumSlaves) : 1;

  typedef logic [SlvW-1:0] slv_idx_t;
  typedef struct packed { logic hit; slv_idx_t idx; } dec_t;
  typedef struct packed {
    logic aw_unmapped, aw_overflow, ar_unmapped, ar_overflow;
    logic b_no_out, b_no_slv, r_no_out, r_no_slv;
  } err_t;

  function automatic dec_t decode(input addr_t addr);
    dec_t d;
    d = '0;
    for (int unsigned i = 0; i < NumAddrRegions; i++) begin
      if (!d.hit && addr >= AddrRegions[i].start_addr && addr <= AddrRegions[i].end_addr) begin
        d.hit = 1'b1;
        d.idx = slv_idx_t'(AddrRegions[i].idx);
      end
    end
    return d;
  endfunction

  aw_chan_t aw;
  ar_chan_t ar;
  b_chan_t  b;
  r_chan_t  r;
  w_chan_t  w_unused;
  logic     aw_fire, ar_fire, b_fire, r_fire, done;
  dec_t     aw_dec, ar_dec;
  err_t     err;
  logic [3:0]  err_add;
  logic [32:0] err_sum;
  logic [31:0] writes_done, reads_done, b_avail, r_avail;
  slv_idx_t    b_head, r_head;
  logic [NumIds-1:0] wq_push, wq_pop, wq_full, wq_empty;
  logic [NumIds-1:0] rq_push, rq_pop, rq_full, rq_empty;
  slv_idx_t          wq_head [NumIds];
  slv_idx_t          rq_head [NumIds];
  logic [NumSlaves-1:0] slv_b_inc, slv_r_inc, slv_b_dec, slv_r_dec;
  logic [31:0]          slv_b_pend [NumSlaves];
  logic [31:0]          slv_r_pend [NumSlaves];

  assign aw       = mon_mst_req_i.aw;
  assign ar       = mon_mst_req_i.ar;
  assign b        = mon_mst_rsp_i.b;
  assign r        = mon_mst_rsp_i.r;
  assign w_unused = mon_mst_req_i.w;
  assign aw_fire  = mon_mst_req_i.aw_valid && mon_mst_rsp_i.aw_ready;
  assign ar_fire  = mon_mst_req_i.ar_valid && mon_mst_rsp_i.ar_ready;
  assign b_fire   = mon_mst_rsp_i.b_valid && mon_mst_req_i.b_ready;
  assign r_fire   = mon_mst_rsp_i.r_valid && mon_mst_req_i.r_ready && r.last;
  assign aw_dec   = decode(aw.addr);
  assign ar_dec   = decode(ar.addr);

  for (genvar i = 0; i < NumIds; i++) begin : g_id
    axi_reorder_cmp_idq #(.Depth(MaxTxnsPerId), .Width(SlvW)) u_wq (
      .clk_i, .rst_ni, .push(wq_push[i]), .pop(wq_pop[i]), .data(aw_dec.idx),
      .head(wq_head[i]), .full(wq_full[i]), .empty(wq_empty[i])
    );
    axi_reorder_cmp_idq #(.Depth(MaxTxnsPerId), .Width(SlvW)) u_rq (
      .clk_i, .rst_ni, .push(rq_push[i]), .pop(rq_pop[i]), .data(ar_dec.idx),
      .head(rq_head[i]), .full(rq_full[i]), .empty(rq_empty[i])
    );
  end

  always_comb begin
    // NOTE: every signal written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    wq_push = '0; wq_pop = '0; rq_push = '0; rq_pop = '0;
    slv_b_dec = '0; slv_r_dec = '0; err = '0;
    for (int s = 0; s < NumSlaves; s++) begin
      slv_b_inc[s] = mon_slv_rsp_i[s].b_valid && mon_slv_req_i[s].b_ready;
      slv_r_inc[s] = mon_slv_rsp_i[s].r_valid && mon_slv_req_i[s].r_ready &&
                     mon_slv_rsp_i[s].r.last;
    end
    // A response arriving at the slave in the same cycle counts as available.
    b_head  = wq_head[b.id];
    r_head  = rq_head[r.id];
    b_avail = slv_b_pend[b_head] + 32'(slv_b_inc[b_head]);
    r_avail = slv_r_pend[r_head] + 32'(slv_r_inc[r_head]);

    if (b_fire) begin
      if (wq_empty[b.id]) err.b_no_out = 1'b1;
      else begin
        wq_pop[b.id] = 1'b1;
        if (b_avail == '0) err.b_no_slv = 1'b1;
        else               slv_b_dec[b_head] = 1'b1;
      end
    end
    if (r_fire) begin
      if (rq_empty[r.id]) err.r_no_out = 1'b1;
      else begin
        rq_pop[r.id] = 1'b1;
        if (r_avail == '0) err.r_no_slv = 1'b1;
        else               slv_r_dec[r_head] = 1'b1;
      end
    end
    if (aw_fire) begin
      if (!aw_dec.hit)                           err.aw_unmapped = 1'b1;
      else if (wq_full[aw.id] && !wq_pop[aw.id]) err.aw_overflow = 1'b1;
      else                                       wq_push[aw.id]  = 1'b1;
    end
    if (ar_fire) begin
      if (!ar_dec.hit)                           err.ar_unmapped = 1'b1;
      else if (rq_full[ar.id] && !rq_pop[ar.id]) err.ar_overflow = 1'b1;
      else                                       rq_push[ar.id]  = 1'b1;
    end

    done = (&wq_empty) && (&rq_empty) &&
           (writes_done >= 32'(NumWrites)) && (reads_done >= 32'(NumReads));
    for (int s = 0; s < NumSlaves; s++) begin
      if (slv_b_pend[s] != '0 || slv_r_pend[s] != '0) done = 1'b0;
    end
  end

  assign err_add = 4'($countones(err));
  assign err_sum = {1'b0, err_cnt_o} + 33'(err_add);
  assign error_o = (err_cnt_o != '0);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      writes_done  <= '0;
      reads_done   <= '0;
      err_cnt_o    <= '0;
      end_of_sim_o <= 1'b0;
      for (int s = 0; s < NumSlaves; s++) begin
        slv_b_pend[s] <= '0;
        slv_r_pend[s] <= '0;
      end
    end else begin
      if (b_fire) writes_done <= writes_done + 32'd1;
      if (r_fire) reads_done  <= reads_done + 32'd1;
      err_cnt_o <= err_sum[32] ? '1 : err_sum[31:0];
      if (done) end_of_sim_o <= 1'b1;
      for (int s = 0; s < NumSlaves; s++) begin
        slv_b_pend[s] <= slv_b_pend[s] + 32'(slv_b_inc[s]) - 32'(slv_b_dec[s]);
        slv_r_pend[s] <= slv_r_pend[s] + 32'(slv_r_inc[s]) - 32'(slv_r_dec[s]);
      end
    end
  end

  logic unused_ok;
  assign unused_ok = ^{mon_mst_req_i, mon_mst_rsp_i, mon_slv_req_i, mon_slv_rsp_i,
                       w_unused, rq_full};

`ifdef AXI_REORDER_CMP_ASSERT_EN
  task automatic report(input err_kind_e kind, input int id, input int slv);
    $error("[%0t] %s id=%0d expected_slave=%0d", $time, kind.name(), id, slv);
  endtask

  always @(posedge clk_i) begin
    if (rst_ni) begin
      if (err.aw_unmapped) report(UNMAPPED, int'(aw.id), -1);
      if (err.aw_overflow) report(OVERFLOW, int'(aw.id), int'(aw_dec.idx));
      if (err.ar_unmapped) report(UNMAPPED, int'(ar.id), -1);
      if (err.ar_overflow) report(OVERFLOW, int'(ar.id), int'(ar_dec.idx));
      if (err.b_no_out)    report(NO_OUTSTANDING, int'(b.id), -1);
      if (err.b_no_slv)    report(NO_SLAVE_RSP, int'(b.id), int'(b_head));
      if (err.r_no_out)    report(NO_OUTSTANDING, int'(r.id), -1);
      if (err.r_no_slv)    report(NO_SLAVE_RSP, int'(r.id), int'(r_head));
      if (Verbose && (aw_fire || ar_fire || b_fire || r_fire))
        $display("[%0t] aw=%0b ar=%0b b=%0b r=%0b", $time, aw_fire, ar_fire, b_fire, r_fire);
      if (done && !end_of_sim_o)
        $display("[%0t] end of sim: writes=%0d reads=%0d errors=%0d",
                 $time, writes_done, reads_done, err_cnt_o);
    end
  end
`else
  logic verbose_unused;
  assign verbose_unused = Verbose;
`endif

endmodule

// File: tb/tb_axi_reorder_cmp.sv
// Self-checking bench for axi_reorder_cmp: table-driven single-event steps plus
// hand-written multi-event sequences, expected values queued per step.
module tb_axi_reorder_cmp;
  import axi_reorder_cmp_pkg::*;

  localparam axi_rule_t [3:0] Map = {
    axi_rule_t'{32'd3, 32'h0010_0000, 32'h0010_FFFF},
    axi_rule_t'{32'd2, 32'h0020_0000, 32'h002F_FFFF},
    axi_rule_t'{32'd1, 32'h0010_0000, 32'h001F_FFFF},
    axi_rule_t'{32'd0, 32'h0000_0000, 32'h000F_FFFF}
  };

  typedef enum {EV_AW, EV_AR, EV_SB, EV_SR, EV_MB, EV_MR, EV_MRNL} ev_e;
  typedef struct {
    logic        do_rst;
    ev_e         ev;
    logic [2:0]  id;
    logic [31:0] addr;
    int          slv;
    logic [31:0] exp_err;
    logic        exp_eos;
    string       name;
  } vec_t;
  typedef struct {
    string       name;
    logic [31:0] exp_err;
    logic        exp_eos;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  axi_req_t         mst_req;
  axi_rsp_t         mst_rsp;
  axi_req_t [3:0]   slv_req;
  axi_rsp_t [3:0]   slv_rsp;
  logic             eos, error;
  logic [31:0]      err_cnt;

  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];
  exp_t sb[$];

  always #5 clk = ~clk;

  axi_reorder_cmp #(
    .AddrRegions(Map), .MaxTxnsPerId(8), .NumWrites(2), .NumReads(2)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .mon_mst_req_i(mst_req), .mon_mst_rsp_i(mst_rsp),
    .mon_slv_req_i(slv_req), .mon_slv_rsp_i(slv_rsp),
    .end_of_sim_o(eos), .error_o(error), .err_cnt_o(err_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clear();
    mst_req = '0; mst_rsp = '0; slv_req = '0; slv_rsp = '0;
  endtask

  task automatic drv_aw(input logic [2:0] id, input logic [31:0] addr);
    mst_req.aw.id = id; mst_req.aw.addr = addr; mst_req.aw_valid = 1'b1; mst_rsp.aw_ready = 1'b1;
  endtask
  task automatic drv_ar(input logic [2:0] id, input logic [31:0] addr);
    mst_req.ar.id = id; mst_req.ar.addr = addr; mst_req.ar_valid = 1'b1; mst_rsp.ar_ready = 1'b1;
  endtask
  task automatic drv_sb(input int s);
    slv_rsp[s].b_valid = 1'b1; slv_req[s].b_ready = 1'b1;
  endtask
  task automatic drv_sr(input int s);
    slv_rsp[s].r_valid = 1'b1; slv_rsp[s].r.last = 1'b1; slv_req[s].r_ready = 1'b1;
  endtask
  task automatic drv_mb(input logic [2:0] id);
    mst_rsp.b.id = id; mst_rsp.b_valid = 1'b1; mst_req.b_ready = 1'b1;
  endtask
  task automatic drv_mr(input logic [2:0] id, input logic last);
    mst_rsp.r.id = id; mst_rsp.r.last = last; mst_rsp.r_valid = 1'b1; mst_req.r_ready = 1'b1;
  endtask

  task automatic apply_reset();
    clear();
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_err_cnt", err_cnt, 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_eos", 32'(eos), 32'd0);
    rst_n = 1'b1;
  endtask

  // Inputs driven before the call take effect on the next edge.
  task automatic step(input string name, input logic [31:0] exp_err, input logic exp_eos);
    exp_t e;
    sb.push_back('{name, exp_err, exp_eos});
    @(posedge clk); #1;
    clear();
    e = sb.pop_front();
    check({e.name, "_err_cnt"}, err_cnt, e.exp_err);
    check({e.name, "_error"}, 32'(error), 32'(e.exp_err != 0));
    check({e.name, "_eos"}, 32'(eos), 32'(e.exp_eos));
  endtask

  task automatic add(input logic r, input ev_e ev, input logic [2:0] id, input logic [31:0] addr,
                     input int slv, input logic [31:0] exp_err, input string name);
    vec_t v;
    v.do_rst = r; v.ev = ev; v.id = id; v.addr = addr; v.slv = slv;
    v.exp_err = exp_err; v.exp_eos = 1'b0; v.name = name;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear();
    repeat (2) @(posedge clk);
    #1;

    add(1, EV_AW, 2, 32'h0012_0010, 0, 0, "t1_aw_s1");
    add(0, EV_SB, 0, 0,             1, 0, "t1_slv_b");
    add(0, EV_MB, 2, 0,             0, 0, "t1_mst_b");
    add(1, EV_MB, 5, 0,             0, 1, "t2_b_no_aw");
    add(0, EV_MRNL, 5, 0,           0, 1, "t2_r_not_last");
    add(1, EV_AR, 1, 32'h0030_0000, 0, 1, "t3_ar_unmapped");
    add(0, EV_MR, 1, 0,             0, 2, "t3_r_nothing_queued");
    add(1, EV_AR, 0, 32'h0000_0100, 0, 0, "t4_ar_s0");
    add(0, EV_AR, 0, 32'h0020_0000, 0, 0, "t4_ar_s2");
    add(0, EV_SR, 0, 0,             2, 0, "t4_slv_r_s2");
    add(0, EV_MR, 0, 0,             0, 1, "t4_mst_r_head_s0");
    add(1, EV_AW, 4, 32'h000F_FFFF, 0, 0, "t5_aw_end_incl");
    add(0, EV_SB, 0, 0,             0, 0, "t5_slv_b_s0");
    add(0, EV_MB, 4, 0,             0, 0, "t5_mst_b_s0");
    add(0, EV_AW, 4, 32'h0010_0000, 0, 0, "t5_aw_first_match");
    add(0, EV_SB, 0, 0,             3, 0, "t5_slv_b_s3");
    add(0, EV_MB, 4, 0,             0, 1, "t5_mst_b_wrong_slv");
    add(0, EV_AR, 7, 32'h002F_FFFF, 0, 1, "t5_ar_last_mapped");
    add(0, EV_AR, 7, 32'h0030_0000, 0, 2, "t5_ar_first_unmapped");

    foreach (vecs[i]) begin
      if (vecs[i].do_rst) apply_reset();
      case (vecs[i].ev)
        EV_AW:   drv_aw(vecs[i].id, vecs[i].addr);
        EV_AR:   drv_ar(vecs[i].id, vecs[i].addr);
        EV_SB:   drv_sb(vecs[i].slv);
        EV_SR:   drv_sr(vecs[i].slv);
        EV_MB:   drv_mb(vecs[i].id);
        EV_MR:   drv_mr(vecs[i].id, 1'b1);
        default: drv_mr(vecs[i].id, 1'b0);
      endcase
      step(vecs[i].name, vecs[i].exp_err, vecs[i].exp_eos);
    end

    // Overflow: the ninth push is dropped, so only eight responses match.
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      drv_aw(3, 32'h0012_0000);
      step("ovf_push", (i < 8) ? 32'd0 : 32'd1, 1'b0);
    end
    for (int i = 0; i < 9; i++) begin
      drv_sb(1); drv_mb(3);
      step("ovf_drain", (i < 8) ? 32'd1 : 32'd2, 1'b0);
    end

    // Same-cycle push/pop, slave increment with master decrement, and two errors at once.
    apply_reset();
    drv_aw(1, 32'h0012_0000);
    step("sc_aw_s1", 0, 1'b0);
    drv_aw(1, 32'h0000_0000); drv_sb(1); drv_mb(1);
    step("sc_push_pop", 0, 1'b0);
    drv_sb(0); drv_mb(1);
    step("sc_head_s0", 0, 1'b0);
    drv_mb(1);
    step("sc_now_empty", 1, 1'b0);
    drv_mb(5); drv_ar(2, 32'h0030_0000);
    step("sc_two_errors", 3, 1'b0);

    // End of simulation with one extra read kept outstanding until late.
    apply_reset();
    for (int i = 0; i < 2; i++) begin
      drv_aw(3'(i), 32'h0000_0010); step("eos_aw", 0, 1'b0);
      drv_sb(0);                    step("eos_sb", 0, 1'b0);
      drv_mb(3'(i));                step("eos_mb", 0, 1'b0);
    end
    drv_ar(6, 32'h0012_0000); step("eos_ar_extra", 0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      drv_ar(2, 32'h0020_0000); step("eos_ar", 0, 1'b0);
      drv_sr(2);                step("eos_sr", 0, 1'b0);
      drv_mr(2, 1'b1);          step("eos_mr", 0, 1'b0);
    end
    step("eos_outstanding", 0, 1'b0);
    drv_sr(1);       step("eos_sr_extra", 0, 1'b0);
    drv_mr(6, 1'b1); step("eos_mr_extra", 0, 1'b0);
    step("eos_set", 0, 1'b1);
    step("eos_sticky", 0, 1'b1);
    apply_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
